// File: rtl/hyperbus_responder.sv
// HyperBus device-side responder at one 16-bit word per clk: decodes the 48-bit CA,
// applies the CR0-selected initial latency and serves register and memory bursts.
module hyperbus_responder #(
   parameter int          ADDR_W  = 10,
   parameter logic [15:0] ID0_VAL = 16'h0C81,
   parameter logic [15:0] ID1_VAL = 16'h0001,
   parameter logic [15:0] CR0_RST = 16'h8F1F,
   parameter logic [15:0] CR1_RST = 16'hFFC1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csn,
   input  logic        ck_en,
   input  logic [15:0] dq_in,
   input  logic        dq_in_oe,
   input  logic        rwds_in,
   input  logic        rwds_in_oe,
   output logic [15:0] dq_out,
   output logic        dq_out_en,
   output logic        rwds_out,
   output logic        rwds_out_en
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CA,
      S_LAT,
      S_RDDATA,
      S_WRDATA,
      S_REGWR,
      S_DONE
   } state_t;

   state_t            state_reg;
   logic [15:0]       ca0_reg;
   logic [15:0]       ca1_reg;
   logic              ca_cnt_reg;
   logic              is_read_reg;
   logic              is_reg_reg;
   logic              linear_reg;
   logic [1:0]        reg_idx_reg;
   logic [4:0]        lat_left_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [15:0]       cr0_reg;
   logic [15:0]       cr1_reg;
   logic [15:0]       reg_q_reg;
   logic [15:0]       mem_q_reg;
   logic              dq_out_en_reg;
   logic              rwds_out_reg;
   logic              rwds_out_en_reg;

   logic [15:0]       mem [DEPTH];

   logic              active;
   logic [31:0]       ca_addr;
   logic [1:0]        ca_reg_idx;
   logic              lat_last;
   logic [ADDR_W-1:0] addr_next;
   logic [15:0]       reg_rd_val;
   logic              rd_fire;
   logic              mem_wr;
   logic              unused_addr_bits;

   // CR0[7:4] selects the base latency; CR0[3] (fixed latency) doubles it.
   function automatic logic [4:0] calc_nlat(input logic [4:0] lat_cfg);
      logic [4:0] base;
      case (lat_cfg[4:1])
         4'b0000: base = 5'd5;
         4'b0001: base = 5'd6;
         4'b1110: base = 5'd3;
         4'b1111: base = 5'd4;
         default: base = 5'd6;
      endcase
      return lat_cfg[0] ? {base[3:0], 1'b0} : base;
   endfunction

   assign active           = !csn && ck_en;
   assign ca_addr          = {ca0_reg[12:0], ca1_reg, dq_in[2:0]};
   assign ca_reg_idx       = {ca1_reg[8], dq_in[0]};
   assign lat_last         = (lat_left_reg == 5'd1);
   assign unused_addr_bits = ^ca_addr[31:ADDR_W];

   // Wrapped bursts only step the low nibble; the 16-word block is held.
   always_comb begin
      addr_next = addr_reg + ADDR_W'(1);
      if (!linear_reg) begin
         addr_next = (addr_reg & ~ADDR_W'(15)) | ((addr_reg + ADDR_W'(1)) & ADDR_W'(15));
      end
   end

   always_comb begin
      reg_rd_val = ID0_VAL;
      case (reg_idx_reg)
         2'b00:   reg_rd_val = ID0_VAL;
         2'b01:   reg_rd_val = ID1_VAL;
         2'b10:   reg_rd_val = cr0_reg;
         default: reg_rd_val = cr1_reg;
      endcase
   end

   assign rd_fire = active && ((state_reg == S_LAT && lat_last && is_read_reg) ||
                               (state_reg == S_RDDATA));
   assign mem_wr  = active && (state_reg == S_WRDATA) && dq_in_oe && !(rwds_in_oe && rwds_in);

   // Storage kept free of reset so it maps onto block RAM with a registered read.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[addr_reg] <= dq_in;
      end
      if (rd_fire) begin
         mem_q_reg <= mem[addr_reg];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= S_IDLE;
         ca0_reg         <= '0;
         ca1_reg         <= '0;
         ca_cnt_reg      <= 1'b0;
         is_read_reg     <= 1'b0;
         is_reg_reg      <= 1'b0;
         linear_reg      <= 1'b0;
         reg_idx_reg     <= '0;
         lat_left_reg    <= '0;
         addr_reg        <= '0;
         cr0_reg         <= CR0_RST;
         cr1_reg         <= CR1_RST;
         reg_q_reg       <= '0;
         dq_out_en_reg   <= 1'b0;
         rwds_out_reg    <= 1'b0;
         rwds_out_en_reg <= 1'b0;
      end else if (csn) begin
         state_reg       <= S_IDLE;
         dq_out_en_reg   <= 1'b0;
         rwds_out_reg    <= 1'b0;
         rwds_out_en_reg <= 1'b0;
      end else if (ck_en) begin
         case (state_reg)
            S_IDLE: begin
               ca0_reg         <= dq_in;
               ca_cnt_reg      <= 1'b0;
               rwds_out_en_reg <= 1'b1;
               rwds_out_reg    <= cr0_reg[3];
               state_reg       <= S_CA;
            end
            S_CA: begin
               if (!ca_cnt_reg) begin
                  ca1_reg    <= dq_in;
                  ca_cnt_reg <= 1'b1;
               end else begin
                  is_read_reg     <= ca0_reg[15];
                  is_reg_reg      <= ca0_reg[14];
                  linear_reg      <= ca0_reg[13];
                  addr_reg        <= ca_addr[ADDR_W-1:0];
                  reg_idx_reg     <= ca_reg_idx;
                  lat_left_reg    <= calc_nlat(cr0_reg[7:3]);
                  rwds_out_en_reg <= 1'b0;
                  rwds_out_reg    <= 1'b0;
                  state_reg       <= (!ca0_reg[15] && ca0_reg[14]) ? S_REGWR : S_LAT;
               end
            end
            S_LAT: begin
               if (lat_last) begin
                  if (is_read_reg) begin
                     dq_out_en_reg   <= 1'b1;
                     rwds_out_en_reg <= 1'b1;
                     rwds_out_reg    <= 1'b1;
                     reg_q_reg       <= reg_rd_val;
                     if (!is_reg_reg) begin
                        addr_reg <= addr_next;
                     end
                     state_reg <= S_RDDATA;
                  end else begin
                     state_reg <= S_WRDATA;
                  end
               end else begin
                  lat_left_reg <= lat_left_reg - 5'd1;
               end
            end
            S_RDDATA: begin
               reg_q_reg <= reg_rd_val;
               if (!is_reg_reg) begin
                  addr_reg <= addr_next;
               end
            end
            S_WRDATA: begin
               addr_reg <= addr_next;
            end
            S_REGWR: begin
               case (reg_idx_reg)
                  2'b10:   cr0_reg <= dq_in;
                  2'b11:   cr1_reg <= dq_in;
                  default: ;
               endcase
               state_reg <= S_DONE;
            end
            S_DONE: ;
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Data is forced to zero whenever the bus is not driven, which also covers reset.
   assign dq_out      = dq_out_en_reg ? (is_reg_reg ? reg_q_reg : mem_q_reg) : 16'h0000;
   assign dq_out_en   = dq_out_en_reg;
   assign rwds_out    = rwds_out_reg;
   assign rwds_out_en = rwds_out_en_reg;

endmodule
